// File: rtl/icache_nway_pkg.sv
// Shared definitions for the N-way instruction cache.
// Holds the refill FSM state type, the address-split width helpers and the
// word-select helper.
package icache_nway_pkg;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        FILL   = 2'd3
    } state_e;

    // Byte-offset bits inside one line.
    function automatic int off_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Set-index bits.
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits left over after index and offset.
    function automatic int tag_bits(input int addr_w, input int sets, input int line_bytes);
        return addr_w - idx_bits(sets) - off_bits(line_bytes);
    endfunction

    // Way-index width; a direct-mapped cache still carries a one-bit index.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // LSB of 32-bit word 'word' inside a line (byte 0 sits in bits [7:0]).
    function automatic int word_lsb(input int word);
        return word * 32;
    endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Refill bus between the instruction cache and the memory side.
//   out_mem_req_valid / in_mem_req_ready : request handshake
//   out_mem_req_addr                     : line-aligned refill address
//   in_mem_resp_valid / in_mem_resp_data : single-beat line response
// master = cache side, slave = memory side.
interface icache_nway_if #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 512
);
    logic              out_mem_req_valid;
    logic              in_mem_req_ready;
    logic [ADDR_W-1:0] out_mem_req_addr;
    logic              in_mem_resp_valid;
    logic [LINE_W-1:0] in_mem_resp_data;

    modport master (
        output out_mem_req_valid, out_mem_req_addr,
        input  in_mem_req_ready, in_mem_resp_valid, in_mem_resp_data
    );

    modport slave (
        input  out_mem_req_valid, out_mem_req_addr,
        output in_mem_req_ready, in_mem_resp_valid, in_mem_resp_data
    );
endinterface

// File: rtl/icache_nway_lru.sv
// True-LRU age tracking, one age counter per way per set.
// Ports: clk/reset; touch_valid/touch_set/touch_way mark a way most recently
// used; victim_set/valid_mask -> victim_way picks the refill target
// (lowest invalid way, else the oldest way whose age is WAYS-1).
module icache_nway_lru
    import icache_nway_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 512
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        touch_valid,
    input  logic [idx_bits(SETS)-1:0]   touch_set,
    input  logic [way_bits(WAYS)-1:0]   touch_way,
    input  logic [idx_bits(SETS)-1:0]   victim_set,
    input  logic [WAYS-1:0]             valid_mask,
    output logic [way_bits(WAYS)-1:0]   victim_way
);
    localparam int WW = way_bits(WAYS);

    generate
        if (WAYS == 1) begin : g_direct
            assign victim_way = '0;
        end else begin : g_lru
            logic [WW-1:0] age_r [SETS][WAYS];
            logic [WW-1:0] first_free_s;
            logic [WW-1:0] oldest_s;

            // Age update: touched way becomes 0, younger ways age by one.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            age_r[s][w] <= WW'(w);
                        end
                    end
                end else if (touch_valid) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WW'(w) == touch_way) begin
                            age_r[touch_set][w] <= '0;
                        end else if (age_r[touch_set][w] < age_r[touch_set][touch_way]) begin
                            age_r[touch_set][w] <= age_r[touch_set][w] + WW'(1);
                        end
                    end
                end
            end

            // Victim search; scanning downward leaves the lowest match.
            always_comb begin
                first_free_s = '0;
                oldest_s     = '0;
                for (int w = WAYS - 1; w >= 0; w--) begin
                    first_free_s = !valid_mask[w] ? WW'(w) : first_free_s;
                    oldest_s     = (age_r[victim_set][w] == WW'(WAYS - 1)) ? WW'(w) : oldest_s;
                end
                victim_way = (&valid_mask) ? oldest_s : first_free_s;
            end
        end
    endgenerate
endmodule

// File: rtl/icache_nway.sv
// N-way set-associative L1 instruction cache with true-LRU replacement.
// Ports: clk, reset (async, active-high); in_pc/in_fetch_valid fetch request;
// in_stall holds outputs; in_flush kills the issuing instruction;
// in_invalidate_all clears every valid bit; mem = refill bus (master side);
// out_instr/out_pc/out_valid registered result; out_miss/out_stall
// combinational lookup status.
module icache_nway
    import icache_nway_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int WAYS           = 4,
    parameter int SETS           = 512,
    parameter int LINE_BYTES     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BUS_DATA_WIDTH-1:0] in_pc,
    input  logic                      in_fetch_valid,
    input  logic                      in_stall,
    input  logic                      in_flush,
    input  logic                      in_invalidate_all,
    icache_nway_if.master             mem,
    output logic [31:0]               out_instr,
    output logic [BUS_DATA_WIDTH-1:0] out_pc,
    output logic                      out_valid,
    output logic                      out_miss,
    output logic                      out_stall
);
    localparam int OFF    = off_bits(LINE_BYTES);
    localparam int IDX    = idx_bits(SETS);
    localparam int TAG    = tag_bits(BUS_DATA_WIDTH, SETS, LINE_BYTES);
    localparam int WW     = way_bits(WAYS);
    localparam int LINE_W = LINE_BYTES * 8;

    logic [LINE_W-1:0] data_mem [WAYS][SETS];
    logic [TAG-1:0]    tag_mem  [WAYS][SETS];
    logic [WAYS-1:0]   valid_r  [SETS];

    state_e            state_r, state_nx_s;
    logic [WW-1:0]     victim_r, victim_s, hit_way_s, touch_way_s;
    logic [LINE_W-1:0] fill_line_r, hit_line_s;
    logic              inv_pend_r;

    logic [IDX-1:0]    idx_s, fill_idx_s, touch_set_s;
    logic [TAG-1:0]    tag_s, fill_tag_s;
    logic [OFF-3:0]    word_s;
    logic [WAYS-1:0]   way_hit_s, victim_mask_s;
    logic              hit_s, lookup_s, lookup_hit_s, touch_s;
    logic [31:0]       hit_word_s;

    assign idx_s      = in_pc[OFF+IDX-1:OFF];
    assign tag_s      = in_pc[BUS_DATA_WIDTH-1:OFF+IDX];
    assign word_s     = in_pc[OFF-1:2];
    // The held request address doubles as the fill address.
    assign fill_idx_s = mem.out_mem_req_addr[OFF+IDX-1:OFF];
    assign fill_tag_s = mem.out_mem_req_addr[BUS_DATA_WIDTH-1:OFF+IDX];

    // Parallel tag compare and hit-line select (at most one way matches).
    always_comb begin
        way_hit_s = '0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit_s[w] = valid_r[idx_s][w] && (tag_mem[w][idx_s] == tag_s);
            hit_way_s    = hit_way_s | (way_hit_s[w] ? WW'(w) : WW'(0));
        end
        hit_s      = |way_hit_s;
        hit_line_s = data_mem[hit_way_s][idx_s];
        hit_word_s = hit_line_s[word_lsb(int'(word_s)) +: 32];
    end

    // An invalidate in LOOKUP forces that cycle's lookup to miss.
    assign lookup_s      = (state_r == LOOKUP) && in_fetch_valid;
    assign lookup_hit_s  = lookup_s && hit_s && !in_invalidate_all;
    assign out_miss      = lookup_s && (!hit_s || in_invalidate_all);
    assign out_stall     = (state_r != LOOKUP) || out_miss;
    assign victim_mask_s = in_invalidate_all ? '0 : valid_r[idx_s];

    assign touch_s     = (lookup_hit_s && !in_stall) || (state_r == FILL);
    assign touch_set_s = (state_r == FILL) ? fill_idx_s : idx_s;
    assign touch_way_s = (state_r == FILL) ? victim_r : hit_way_s;

    icache_nway_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk         (clk),
        .reset       (reset),
        .touch_valid (touch_s),
        .touch_set   (touch_set_s),
        .touch_way   (touch_way_s),
        .victim_set  (idx_s),
        .valid_mask  (victim_mask_s),
        .victim_way  (victim_s)
    );

    // Next-state logic; stall only blocks leaving LOOKUP.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            LOOKUP: if (out_miss && !in_stall) state_nx_s = REQ;  else state_nx_s = LOOKUP;
            REQ:    if (mem.in_mem_req_ready)  state_nx_s = WAIT; else state_nx_s = REQ;
            WAIT:   if (mem.in_mem_resp_valid) state_nx_s = FILL; else state_nx_s = WAIT;
            FILL:   state_nx_s = LOOKUP;
            default: state_nx_s = LOOKUP;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= LOOKUP;
        else       state_r <= state_nx_s;
    end

    // Refill control: request, victim, fill line and deferred invalidate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.out_mem_req_valid <= 1'b0;
            mem.out_mem_req_addr  <= '0;
            victim_r              <= '0;
            fill_line_r           <= '0;
            inv_pend_r            <= 1'b0;
        end else begin
            if (state_r == LOOKUP && state_nx_s == REQ) begin
                mem.out_mem_req_valid <= 1'b1;
                mem.out_mem_req_addr  <= {in_pc[BUS_DATA_WIDTH-1:OFF], {OFF{1'b0}}};
                victim_r              <= victim_s;
            end else if (state_r == REQ && mem.in_mem_req_ready) begin
                mem.out_mem_req_valid <= 1'b0;
            end
            if (state_r == WAIT && mem.in_mem_resp_valid) begin
                fill_line_r <= mem.in_mem_resp_data;
            end
            if (state_r == FILL)                               inv_pend_r <= 1'b0;
            else if (state_r != LOOKUP && in_invalidate_all)   inv_pend_r <= 1'b1;
        end
    end

    // Valid bits; a pending invalidate also drops the line being installed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) valid_r[s] <= '0;
        end else if ((state_r == LOOKUP && in_invalidate_all) ||
                     (state_r == FILL && (inv_pend_r || in_invalidate_all))) begin
            for (int s = 0; s < SETS; s++) valid_r[s] <= '0;
        end else if (state_r == FILL) begin
            valid_r[fill_idx_s][victim_r] <= 1'b1;
        end
    end

    // Tag and data arrays are written only in FILL and carry no reset.
    always_ff @(posedge clk) begin
        if (state_r == FILL) begin
            data_mem[victim_r][fill_idx_s] <= fill_line_r;
            tag_mem[victim_r][fill_idx_s]  <= fill_tag_s;
        end
    end

    // Registered fetch result; stall holds, flush kills the issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_instr <= 32'd0;
            out_pc    <= '0;
            out_valid <= 1'b0;
        end else if (!in_stall) begin
            if (in_flush) begin
                out_valid <= 1'b0;
                out_instr <= 32'd0;
            end else if (lookup_hit_s) begin
                out_valid <= 1'b1;
                out_instr <= hit_word_s;
                out_pc    <= in_pc;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway: stimulus pushes expected issues into a
// queue, a monitor pops and compares on every issuing edge with out_valid=1.
module tb_icache_nway;
    localparam int AW = 64;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] in_pc = 64'd0;
    logic          in_fetch_valid = 1'b0;
    logic          in_stall = 1'b0;
    logic          in_flush = 1'b0;
    logic          in_invalidate_all = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic          out_valid, out_miss, out_stall;

    icache_nway_if #(.ADDR_W(AW), .LINE_W(LW)) mem_bus ();

    icache_nway dut (
        .clk               (clk),
        .reset             (reset),
        .in_pc             (in_pc),
        .in_fetch_valid    (in_fetch_valid),
        .in_stall          (in_stall),
        .in_flush          (in_flush),
        .in_invalidate_all (in_invalidate_all),
        .mem               (mem_bus),
        .out_instr         (out_instr),
        .out_pc            (out_pc),
        .out_valid         (out_valid),
        .out_miss          (out_miss),
        .out_stall         (out_stall)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] pc; logic [31:0] instr; } exp_t;
    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_instr = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Memory content: 0x1000 holds 0x00500093, every other word differs.
    function automatic logic [31:0] instr_at(input logic [AW-1:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return 32'h0050_0093 + lo - 32'h0000_1000;
    endfunction

    function automatic logic [LW-1:0] line_at(input logic [AW-1:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = instr_at(base + 64'(k * 4));
        return l;
    endfunction

    task automatic fetch_hit(input logic [AW-1:0] pc);
        in_pc = pc; in_fetch_valid = 1'b1; #1;
        check("hit_out_miss", {63'd0, out_miss}, 64'd0);
        check("hit_no_req", {63'd0, mem_bus.out_mem_req_valid}, 64'd0);
        exp_q.push_back('{pc: pc, instr: instr_at(pc)});
        last_instr = instr_at(pc);
        @(negedge clk);
    endtask

    task automatic fetch_miss(input logic [AW-1:0] pc);
        in_pc = pc; in_fetch_valid = 1'b1; #1;
        check("miss_out_miss", {63'd0, out_miss}, 64'd1);
        check("miss_out_stall", {63'd0, out_stall}, 64'd1);
        @(negedge clk);
    endtask

    // Acts as the bus: waits for the request, delays ready, answers later.
    task automatic serve(input logic [AW-1:0] addr, input int ready_dly, input int resp_dly, input logic inv_in_wait);
        int n;
        n = 0;
        while (mem_bus.out_mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        check("req_seen", {63'd0, mem_bus.out_mem_req_valid}, 64'd1);
        if (n >= 20) return;
        check("req_addr", mem_bus.out_mem_req_addr, addr);
        for (int i = 0; i < ready_dly; i++) begin
            @(negedge clk);
            check("req_hold_valid", {63'd0, mem_bus.out_mem_req_valid}, 64'd1);
            check("req_hold_addr", mem_bus.out_mem_req_addr, addr);
        end
        mem_bus.in_mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.in_mem_req_ready = 1'b0;
        check("req_done", {63'd0, mem_bus.out_mem_req_valid}, 64'd0);
        for (int i = 0; i < resp_dly; i++) begin
            in_invalidate_all = inv_in_wait && (i == 0);
            @(negedge clk);
        end
        in_invalidate_all = 1'b0;
        mem_bus.in_mem_resp_valid = 1'b1;
        mem_bus.in_mem_resp_data  = line_at(addr);
        @(negedge clk);
        mem_bus.in_mem_resp_valid = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: an issuing edge is one with reset and in_stall low.
    initial begin
        logic prev_stall, prev_rst;
        exp_t e;
        forever begin
            @(posedge clk);
            prev_stall = in_stall;
            prev_rst   = reset;
            #1;
            if (!prev_rst && !prev_stall && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
                    check("out_pc", out_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_bus.in_mem_req_ready  = 1'b0;
        mem_bus.in_mem_resp_valid = 1'b0;
        mem_bus.in_mem_resp_data  = '0;

        // Reset state.
        @(negedge clk); @(negedge clk);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_req_valid", {63'd0, mem_bus.out_mem_req_valid}, 64'd0);
        check("rst_req_addr", mem_bus.out_mem_req_addr, 64'd0);
        reset = 1'b0;

        // Cold miss, response two cycles after the request completes.
        fetch_miss(64'h1000);
        serve(64'h1000, 0, 2, 1'b0);
        fetch_hit(64'h1000);

        // Hit stream across the whole line.
        for (int k = 0; k < 16; k++) fetch_hit(64'h1000 + 64'(k * 4));

        // LRU: fill all four ways of set 0, re-touch 0x0000, evict.
        for (int k = 0; k < 4; k++) begin
            fetch_miss(64'(k) * 64'h8000);
            serve(64'(k) * 64'h8000, 0, 1, 1'b0);
            fetch_hit(64'(k) * 64'h8000);
        end
        fetch_hit(64'h0000);
        fetch_miss(64'h20000);
        serve(64'h20000, 0, 1, 1'b0);
        fetch_hit(64'h20000);
        fetch_hit(64'h0000);
        fetch_hit(64'h10000);
        fetch_hit(64'h18000);
        fetch_miss(64'h8000);
        serve(64'h8000, 0, 1, 1'b0);
        fetch_hit(64'h8000);

        // Stall: miss held in LOOKUP, then backpressure with stall high.
        in_pc = 64'h2000; in_fetch_valid = 1'b1; in_stall = 1'b1; #1;
        check("stall_miss", {63'd0, out_miss}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_no_req", {63'd0, mem_bus.out_mem_req_valid}, 64'd0);
        end
        in_stall = 1'b0;
        @(negedge clk);
        in_stall = 1'b1;
        serve(64'h2000, 5, 1, 1'b0);
        check("stall_instr_held", {32'd0, out_instr}, {32'd0, last_instr});
        check("stall_valid_low", {63'd0, out_valid}, 64'd0);
        check("stall_filled_hit", {63'd0, out_stall}, 64'd0);
        in_stall = 1'b0;
        fetch_hit(64'h2000);

        // Flush on a hit edge.
        in_pc = 64'h1004; in_fetch_valid = 1'b1; in_flush = 1'b1; #1;
        check("flush_hit", {63'd0, out_miss}, 64'd0);
        @(negedge clk);
        in_flush = 1'b0; in_fetch_valid = 1'b0;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_instr", {32'd0, out_instr}, 64'd0);

        // Invalidate during WAIT: cached 0x1000 misses afterwards.
        fetch_miss(64'h3000);
        serve(64'h3000, 0, 2, 1'b1);
        fetch_miss(64'h1000);
        serve(64'h1000, 0, 1, 1'b0);
        fetch_hit(64'h1000);

        // Asynchronous reset while waiting for the response.
        fetch_miss(64'h4000);
        mem_bus.in_mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.in_mem_req_ready = 1'b0;
        in_fetch_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_req_valid", {63'd0, mem_bus.out_mem_req_valid}, 64'd0);
        check("arst_out_stall", {63'd0, out_stall}, 64'd0);
        check("arst_out_pc", out_pc, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        fetch_miss(64'h1000);
        serve(64'h1000, 0, 1, 1'b0);
        fetch_hit(64'h1000);

        in_fetch_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative L1 instruction cache with true-LRU replacement (age counters per set).
- Sits between the fetch PC register and the bus refill path.
- Accepts a fetch PC and returns one 32-bit instruction per cycle on a hit.
- Adds over the 2-way generation: configurable ways, sets and line size; a request/response refill handshake; whole-cache invalidate; and correct per-set LRU.

Parameters:
- BUS_DATA_WIDTH, 64: PC and address width.
- WAYS, 4: associativity; power of two, 1..8.
- SETS, 512: sets per way; power of two.
- LINE_BYTES, 64: line size; power of two, at least 8. Refill data width is LINE_BYTES*8.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_pc  in  BUS_DATA_WIDTH  fetch address; bits [1:0] are ignored.
- in_fetch_valid  in  1  fetch request this cycle.
- in_stall  in  1  downstream stall (hazard unit or dcache); holds outputs.
- in_flush  in  1  jump/ecall flush; kills the instruction being issued.
- in_invalidate_all  in  1  clear all valid bits (fence.i).
- out_mem_req_valid  out  1  refill request.
- in_mem_req_ready  in  1  bus accepts the request.
- out_mem_req_addr  out  BUS_DATA_WIDTH  line-aligned refill address.
- in_mem_resp_valid  in  1  refill line present (single beat).
- in_mem_resp_data  in  LINE_BYTES*8  refill line, byte 0 in bits [7:0].
- out_instr  out  32  registered instruction.
- out_pc  out  BUS_DATA_WIDTH  PC of out_instr.
- out_valid  out  1  out_instr is valid.
- out_miss  out  1  combinational: lookup missed this cycle.
- out_stall  out  1  combinational: PC must hold.

Behaviour:
- Address split:
  - OFF = log2(LINE_BYTES), IDX = log2(SETS), TAG = BUS_DATA_WIDTH-IDX-OFF.
  - index = pc[OFF+IDX-1:OFF], tag = pc[BUS_DATA_WIDTH-1:OFF+IDX], word = pc[OFF-1:2].
- Storage:
  - Data and tag arrays have no reset.
  - Valid bits (SETS*WAYS flops) and LRU ages (SETS*WAYS*log2(WAYS) bits) reset asynchronously.
  - On reset, valid = 0 and the age of way w = w.
- Reset values: out_instr=0, out_pc=0, out_valid=0, out_mem_req_valid=0, out_mem_req_addr=0; FSM in LOOKUP.
- FSM states: LOOKUP, REQ, WAIT, FILL.
  - LOOKUP, in_fetch_valid=1:
    - Tag-compare all ways in parallel.
    - Hit: out_miss=0, out_stall=0. At the next edge, out_instr = selected word and out_pc = in_pc, and LRU is updated.
    - Miss: out_miss=1, out_stall=1. Latch the line-aligned PC and the victim way, then go to REQ.
  - REQ:
    - out_mem_req_valid=1; the address is held stable until in_mem_req_ready=1, then go to WAIT.
    - Request and ready in the same cycle completes the transfer.
  - WAIT: go to FILL on in_mem_resp_valid=1, capturing the line into the fill register. in_mem_resp_valid outside WAIT is ignored.
  - FILL: write data, tag and valid=1 into the victim way, touch LRU for that way, return to LOOKUP. The repeated lookup hits the following cycle.
  - Miss latency from the miss cycle to the hit cycle is 3 + bus latency.
  - out_stall=1 in REQ, WAIT and FILL.
- LRU: on access to way a, set age[a]=0 and increment every way whose age < old age[a]. The victim is the lowest-numbered invalid way, else the way with age WAYS-1. WAYS=1 has no LRU state.
- in_stall=1:
  - out_instr, out_pc and out_valid hold; no LRU update.
  - The LOOKUP→REQ transition is suppressed.
  - REQ, WAIT and FILL still advance, so a bus response is never dropped.
- in_flush=1 on an issuing edge: out_valid <= 0 and out_instr <= 0, and out_pc is not updated. A refill in flight always completes; the line is installed.
- in_invalidate_all:
  - In LOOKUP: all valid bits clear at the next edge, and that cycle's lookup reports a miss.
  - In other states: the invalidate is latched as pending and applied in the cycle FILL returns to LOOKUP, which also drops the just-filled line.
- out_valid=0 while out_stall=1, or when in_fetch_valid=0 at an issuing edge.
- Asynchronous reset mid-refill: the FSM returns to LOOKUP immediately and the request is dropped. The bus must tolerate the abandoned request.

Decomposition:
- Package icache_pkg: state enum (LOOKUP/REQ/WAIT/FILL), address-split localparam functions (OFF, IDX, TAG), word-select helper.
- One sub-module, icache_lru: per-set age array, touch port (set, way), victim port (set, valid mask) returning a way index.
- Tag/data arrays and the FSM stay in the top level.

Test Plan:
- Cold miss: reset, pc=0x1000, ready=1, response 2 cycles later with word0=0x00500093 -> out_miss=1 at cycle 0; out_mem_req_addr=0x1000; out_instr=0x00500093, out_valid=1 on the first hit edge after FILL.
- Hit stream: pcs 0x1000,0x1004,...,0x103C -> 16 consecutive out_valid=1 cycles, no requests.
- LRU eviction (WAYS=4): fill tags for pcs 0x0000, 0x8000, 0x10000, 0x18000 (same set); re-touch 0x0000; miss 0x20000 -> victim is the way holding 0x8000; 0x0000 still hits.
- Stall/backpressure: hold in_mem_req_ready=0 for 5 cycles with in_stall=1 -> addr stable, out_instr unchanged; response with in_stall=1 still fills, and the hit issues after in_stall drops.
- Flush and invalidate: in_flush on a hit edge -> out_valid=0; in_invalidate_all during WAIT -> after FILL, pc 0x1000 misses again.
- Async reset in WAIT -> out_mem_req_valid=0 immediately; next fetch of a previously cached pc misses.
